cook_timer_control: RTL
=======================

COOK_TIMER_CONTROL -- requirements
Module: cook_timer_control

Interface
REQ-001 SHALL have parameter DONE_CYCLES, default 8, meaning the number of clk cycles the DONE state is held before returning to IDLE.
REQ-002 SHALL have parameter BEEP_DIV, default 2, meaning the beep toggles every BEEP_DIV clk cycles while in DONE (used only with BEEP_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  keypad digit strobe, level; only its rising edge is used.
REQ-006 SHALL have port start  input  1  start request, level, sampled every cycle.
REQ-007 SHALL have port stop  input  1  stop/pause request, level, sampled every cycle.
REQ-008 SHALL have port door_closed  input  1  1 = door closed.
REQ-009 SHALL have port sec_tick  input  1  one-cycle 1 Hz timebase pulse.
REQ-010 SHALL have port zero  input  1  counter reports 0:00.
REQ-011 SHALL have port loadn  output  1  counter digit-shift load, active-low.
REQ-012 SHALL have port cnt_clrn  output  1  counter clear, active-low.
REQ-013 SHALL have port cnt_enable  output  1  counter decrement enable.
REQ-014 SHALL have port mag_on  output  1  magnetron drive.
REQ-015 SHALL have port state  output  3  current FSM state code.
REQ-016 SHALL have port beep  output  1  done alarm (BEEP_EN only).

Function
REQ-017 SHALL implement FSM states IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-018 SHALL register all outputs; each output reflects the state/event sampled on the previous edge (1-cycle latency).
REQ-019 SHALL, on a key_valid rising edge in IDLE, SET or PAUSE, drive loadn low for exactly one cycle and enter SET (PAUSE->SET loads digit, discards remaining pause).
REQ-020 SHALL ignore key_valid edges in COOK and DONE (loadn stays 1).
REQ-021 SHALL move SET or PAUSE -> COOK on start when door_closed=1 and zero=0; start with door open or zero=1 is ignored.
REQ-022 SHALL, in COOK, assert mag_on=1 and pulse cnt_enable for one cycle following each sec_tick.
REQ-023 SHALL move COOK -> PAUSE on stop or door_closed=0; mag_on and cnt_enable drop with the transition.
REQ-024 SHALL move COOK -> DONE when zero=1; zero has priority over stop/door in the same cycle.
REQ-025 SHALL, on stop in SET or PAUSE, pulse cnt_clrn low one cycle and enter IDLE.
REQ-026 SHALL give stop priority over start when both asserted in the same cycle.
REQ-027 SHALL hold DONE for DONE_CYCLES cycles (internal counter, width clog2(DONE_CYCLES+1)), then pulse cnt_clrn low one cycle and enter IDLE.
REQ-028 SHALL keep mag_on=0 in every state except COOK.

Reset
REQ-029 SHALL, while clr=1, force state=IDLE, loadn=1, cnt_clrn=0, cnt_enable=0, mag_on=0, beep=0, clear all internal counters and edge-detect history.
REQ-030 SHALL release cnt_clrn to 1 on the first edge after clr deasserts; clr mid-COOK immediately deasserts mag_on.

Configuration
REQ-031 SHALL compile the beep generator only when COOK_BEEP_EN is defined: beep toggles every BEEP_DIV cycles in DONE, 0 elsewhere.
REQ-032 SHALL, without COOK_BEEP_EN, omit the beep port and BEEP_DIV logic; all other behaviour identical.

Structure
REQ-033 SHALL take state codes and DONE_CYCLES default from shared include timer_defs.vh, also used by the counter benches.
REQ-034 SHALL instantiate one sub-module rise_detect (1-bit registered rising-edge detector) for key_valid.

Verification
REQ-035 SHALL cover: clr, then key_valid edges with digits 1,2,0 -> three single-cycle loadn lows, state=SET.
REQ-036 SHALL cover: SET, door_closed=1, start -> COOK next cycle, mag_on=1, cnt_enable pulses once per sec_tick.
REQ-037 SHALL cover: COOK, door_closed->0 -> PAUSE, mag_on=0; door closed + start -> COOK resumes without cnt_clrn.
REQ-038 SHALL cover: COOK, zero=1 with stop=1 same cycle -> DONE, 8 cycles later cnt_clrn low one cycle, IDLE.
REQ-039 SHALL cover: SET, start=1 and stop=1 together -> cnt_clrn pulse, IDLE, mag_on never 1.
REQ-040 SHALL cover: clr asserted mid-COOK -> mag_on=0 and cnt_clrn=0 immediately, IDLE after release.

Source files
------------

// File: rtl/cook_timer_control_pkg.sv
// Shared definitions for the cook timer controller and the counter benches:
// FSM state codes and default timing constants.
package cook_timer_control_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned DONE_CYCLES_DEF = 8;
    localparam int unsigned BEEP_DIV_DEF    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector: registered history, pulse high for the cycle
// where the input is 1 and was 0 on the previous edge.
module rise_detect (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic rise_c
);

    logic din_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise_c = din & ~din_q;

endmodule

// File: rtl/cook_timer_control.sv
// Microwave cook timer control FSM (IDLE/SET/COOK/PAUSE/DONE) with registered
// outputs. Optional done-alarm beep generator when COOK_BEEP_EN is defined.
module cook_timer_control
    import cook_timer_control_pkg::*;
#(
    parameter int unsigned DONE_CYCLES = DONE_CYCLES_DEF
`ifdef COOK_BEEP_EN
    ,
    parameter int unsigned BEEP_DIV    = BEEP_DIV_DEF
`endif
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               key_valid,
    input  logic               start,
    input  logic               stop,
    input  logic               door_closed,
    input  logic               sec_tick,
    input  logic               zero,
    output logic               loadn,
    output logic               cnt_clrn,
    output logic               cnt_enable,
    output logic               mag_on,
    output logic [STATE_W-1:0] state
`ifdef COOK_BEEP_EN
    ,
    output logic               beep
`endif
);

    localparam int unsigned DONE_W = $clog2(DONE_CYCLES + 1);

    state_t            state_q;
    state_t            state_nxt;
    logic [DONE_W-1:0] done_cnt;
    logic              key_rise_c;
    logic              load_c;
    logic              clear_c;
    logic              done_last_c;

    rise_detect u_key_rise (
        .clk    (clk),
        .clr    (clr),
        .din    (key_valid),
        .rise_c (key_rise_c)
    );

    assign done_last_c = (done_cnt == DONE_W'(DONE_CYCLES - 1));

    // Next state plus the one-cycle load/clear events it implies; stop beats
    // key entry, key entry beats start.
    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        clear_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_rise_c) begin
                    state_nxt = ST_SET;
                    load_c    = 1'b1;
                end
            end
            ST_SET, ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    clear_c   = 1'b1;
                end else if (key_rise_c) begin
                    state_nxt = ST_SET;
                    load_c    = 1'b1;
                end else if (start && door_closed && !zero) begin
                    state_nxt = ST_COOK;
                end
            end
            ST_COOK: begin
                if (zero)                      state_nxt = ST_DONE;
                else if (stop || !door_closed) state_nxt = ST_PAUSE;
            end
            ST_DONE: begin
                if (done_last_c) begin
                    state_nxt = ST_IDLE;
                    clear_c   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            loadn      <= 1'b1;
            cnt_clrn   <= 1'b0;
            cnt_enable <= 1'b0;
            mag_on     <= 1'b0;
            done_cnt   <= '0;
        end else begin
            state_q    <= state_nxt;
            loadn      <= ~load_c;
            cnt_clrn   <= ~clear_c;
            // Decrement only while cooking continues past this edge.
            cnt_enable <= sec_tick && (state_q == ST_COOK) && (state_nxt == ST_COOK);
            mag_on     <= (state_nxt == ST_COOK);
            if (state_q == ST_DONE && !done_last_c) done_cnt <= done_cnt + DONE_W'(1);
            else                                    done_cnt <= '0;
        end
    end

    assign state = state_q;

`ifdef COOK_BEEP_EN
    localparam int unsigned BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    logic [BEEP_W-1:0] beep_cnt;

    // Square-wave alarm while the FSM stays in DONE; silent otherwise.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_q == ST_DONE && state_nxt == ST_DONE) begin
            if (beep_cnt == BEEP_W'(BEEP_DIV - 1)) begin
                beep     <= ~beep;
                beep_cnt <= '0;
            end else begin
                beep_cnt <= beep_cnt + BEEP_W'(1);
            end
        end else begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end
    end
`endif

endmodule
